// File: rtl/max7219_rx.sv
// max7219_rx: receive-side model of a cascaded MAX7219 chain.
// Oversamples din/cs/sclk in the clk domain, shifts one 16-bit word per chip
// while cs is low, and on the cs rising edge (LOAD) updates the per-chip
// register file when exactly 16*NCHIP bits arrived.
module max7219_rx #(
   parameter int unsigned NCHIP = 4,
   parameter int unsigned SYNC  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  din,
   input  logic                  cs,
   input  logic                  sclk,
   output logic [64*NCHIP-1:0]   leds,
   output logic [4*NCHIP-1:0]    intensity,
   output logic [3*NCHIP-1:0]    scan_limit,
   output logic [8*NCHIP-1:0]    decode,
   output logic [NCHIP-1:0]      shutdown_n,
   output logic [NCHIP-1:0]      disp_test,
   output logic                  frame_stb,
   output logic                  frame_err,
   output logic [15:0]           bit_count
);

   localparam int unsigned NBITS = 16 * NCHIP;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH
   } state_e;

   // input synchronisers and edge-detect history
   logic [SYNC-1:0]      din_sync_q, cs_sync_q, sclk_sync_q;
   logic                 cs_prev_q, sclk_prev_q;
   logic [SYNC:0]        live_q;
   logic                 din_s, cs_s, sclk_s;
   logic                 cs_fall, cs_rise, sclk_rise;

   // receive state
   state_e               state_q, state_d;
   logic [NBITS-1:0]     sr_q, sr_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [15:0]          cnt_inc;
   logic [15:0]          bit_count_q, bit_count_d;
   logic                 stb_q, stb_d;
   logic                 err_q, err_d;

   // register file
   logic [64*NCHIP-1:0]  leds_q, leds_d;
   logic [4*NCHIP-1:0]   intensity_q, intensity_d;
   logic [3*NCHIP-1:0]   scan_q, scan_d;
   logic [8*NCHIP-1:0]   decode_q, decode_d;
   logic [NCHIP-1:0]     shdn_q, shdn_d;
   logic [NCHIP-1:0]     test_q, test_d;

   logic [3:0]           addr;
   logic [7:0]           data;

   // The top bit of the chain is only ever the don't-care nibble of the far chip.
   logic                 unused_top;
   assign unused_top = sr_q[NBITS-1];

   // Synchronise the serial lines; live_q marks when the history holds real pin samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_sync_q  <= '0;
         cs_sync_q   <= '1;
         sclk_sync_q <= '0;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         live_q      <= '0;
      end else begin
         din_sync_q  <= {din_sync_q[SYNC-2:0], din};
         cs_sync_q   <= {cs_sync_q[SYNC-2:0], cs};
         sclk_sync_q <= {sclk_sync_q[SYNC-2:0], sclk};
         cs_prev_q   <= cs_sync_q[SYNC-1];
         sclk_prev_q <= sclk_sync_q[SYNC-1];
         live_q      <= {live_q[SYNC-1:0], 1'b1};
      end
   end

   assign din_s  = din_sync_q[SYNC-1];
   assign cs_s   = cs_sync_q[SYNC-1];
   assign sclk_s = sclk_sync_q[SYNC-1];

   // Edges are suppressed until the reset presets have flushed out, so a cs line
   // held low across reset release does not look like a fresh falling edge.
   assign cs_fall   = live_q[SYNC] &  cs_prev_q & ~cs_s;
   assign cs_rise   = live_q[SYNC] & ~cs_prev_q &  cs_s;
   assign sclk_rise = live_q[SYNC] & ~sclk_prev_q & sclk_s;

   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   // Receive FSM state, shift register, counters and register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         bit_count_q <= '0;
         stb_q       <= 1'b0;
         err_q       <= 1'b0;
         leds_q      <= '0;
         intensity_q <= '0;
         scan_q      <= '0;
         decode_q    <= '0;
         shdn_q      <= '0;
         test_q      <= '0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         bit_count_q <= bit_count_d;
         stb_q       <= stb_d;
         err_q       <= err_d;
         leds_q      <= leds_d;
         intensity_q <= intensity_d;
         scan_q      <= scan_d;
         decode_q    <= decode_d;
         shdn_q      <= shdn_d;
         test_q      <= test_d;
      end
   end

   // Next-state: shifting while cs low, word decode on the LATCH cycle.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      bit_count_d = bit_count_q;
      stb_d       = 1'b0;
      err_d       = 1'b0;
      leds_d      = leds_q;
      intensity_d = intensity_q;
      scan_d      = scan_q;
      decode_d    = decode_q;
      shdn_d      = shdn_q;
      test_d      = test_q;
      addr        = '0;
      data        = '0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_SHIFT;
               sr_d    = '0;
               cnt_d   = '0;
               // an sclk edge in the same sample as cs falling is the first bit
               if (sclk_rise) begin
                  sr_d  = {{(NBITS-1){1'b0}}, din_s};
                  cnt_d = 16'd1;
               end
            end
         end

         ST_SHIFT: begin
            if (sclk_rise) begin
               sr_d  = {sr_q[NBITS-2:0], din_s};
               cnt_d = cnt_inc;
            end
            if (cs_rise) begin
               state_d = ST_LATCH;
            end
         end

         ST_LATCH: begin
            state_d     = ST_IDLE;
            bit_count_d = cnt_q;
            if (cnt_q == 16'(NBITS)) begin
               stb_d = 1'b1;
               for (int unsigned k = 0; k < NCHIP; k++) begin
                  addr = sr_q[16*k+8 +: 4];
                  data = sr_q[16*k +: 8];
                  case (addr)
                     4'h9: decode_d[8*k +: 8]    = data;
                     4'hA: intensity_d[4*k +: 4] = data[3:0];
                     4'hB: scan_d[3*k +: 3]      = data[2:0];
                     4'hC: shdn_d[k]             = data[0];
                     4'hF: test_d[k]             = data[0];
                     default: begin
                        for (int unsigned d = 0; d < 8; d++) begin
                           if (addr == 4'(d + 1)) begin
                              leds_d[64*k + 8*d +: 8] = data;
                           end
                        end
                     end
                  endcase
               end
            end else begin
               err_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign leds       = leds_q;
   assign intensity  = intensity_q;
   assign scan_limit = scan_q;
   assign decode     = decode_q;
   assign shutdown_n = shdn_q;
   assign disp_test  = test_q;
   assign frame_stb  = stb_q;
   assign frame_err  = err_q;
   assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: randomized frames against a word-level model of the MAX7219 chain.
module tb_max7219_rx;

   localparam int NCHIP = 4;
   localparam int SYNC  = 2;
   localparam int NB    = 16 * NCHIP;
   localparam int NREG  = 64*NCHIP + 4*NCHIP + 3*NCHIP + 8*NCHIP + 2*NCHIP;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                din = 1'b0;
   logic                cs = 1'b1;
   logic                sclk = 1'b0;
   logic [64*NCHIP-1:0] leds;
   logic [4*NCHIP-1:0]  intensity;
   logic [3*NCHIP-1:0]  scan_limit;
   logic [8*NCHIP-1:0]  decode;
   logic [NCHIP-1:0]    shutdown_n;
   logic [NCHIP-1:0]    disp_test;
   logic                frame_stb;
   logic                frame_err;
   logic [15:0]         bit_count;
   logic [NREG-1:0]     dut_regs;

   max7219_rx #(.NCHIP(NCHIP), .SYNC(SYNC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .cs         (cs),
      .sclk       (sclk),
      .leds       (leds),
      .intensity  (intensity),
      .scan_limit (scan_limit),
      .decode     (decode),
      .shutdown_n (shutdown_n),
      .disp_test  (disp_test),
      .frame_stb  (frame_stb),
      .frame_err  (frame_err),
      .bit_count  (bit_count)
   );

   assign dut_regs = {leds, intensity, scan_limit, decode, shutdown_n, disp_test};

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int stb_seen = 0, err_seen = 0;
   int exp_stb  = 0, exp_err  = 0;

   // count pulse-cycles; a pulse longer than one cycle counts more than once
   always @(negedge clk) begin
      if (frame_stb === 1'b1) stb_seen++;
      if (frame_err === 1'b1) err_seen++;
   end

   // reference model: chip register file at word level
   logic [7:0] m_dig [NCHIP][8];
   logic [3:0] m_int [NCHIP];
   logic [2:0] m_scan[NCHIP];
   logic [7:0] m_dec [NCHIP];
   logic       m_shd [NCHIP];
   logic       m_tst [NCHIP];
   int         m_bc;
   bit         q[$];

   function automatic void model_reset();
      for (int k = 0; k < NCHIP; k++) begin
         for (int d = 0; d < 8; d++) m_dig[k][d] = 8'h00;
         m_int[k] = '0; m_scan[k] = '0; m_dec[k] = '0; m_shd[k] = 1'b0; m_tst[k] = 1'b0;
      end
      m_bc = 0;
   endfunction

   // apply the bits queued in q as one LOAD window
   function automatic void model_frame();
      int n;
      logic [15:0] w;
      n = q.size();
      m_bc = (n > 65535) ? 65535 : n;
      if (n != NB) begin
         exp_err++;
         return;
      end
      exp_stb++;
      for (int k = 0; k < NCHIP; k++) begin
         // the far chip's word is shifted first; chip 0 gets the last 16 bits
         for (int b = 0; b < 16; b++) w[15-b] = q[(NCHIP-1-k)*16 + b];
         case (w[11:8])
            4'h0, 4'hD, 4'hE: ;
            4'h9: m_dec[k]  = w[7:0];
            4'hA: m_int[k]  = w[3:0];
            4'hB: m_scan[k] = w[2:0];
            4'hC: m_shd[k]  = w[0];
            4'hF: m_tst[k]  = w[0];
            default: m_dig[k][w[11:8]-1] = w[7:0];
         endcase
      end
   endfunction

   function automatic logic [NREG-1:0] exp_regs();
      logic [64*NCHIP-1:0] l;
      logic [4*NCHIP-1:0]  it;
      logic [3*NCHIP-1:0]  sl;
      logic [8*NCHIP-1:0]  dc;
      logic [NCHIP-1:0]    sd, dt;
      for (int k = 0; k < NCHIP; k++) begin
         for (int d = 0; d < 8; d++) l[64*k + 8*d +: 8] = m_dig[k][d];
         it[4*k +: 4] = m_int[k];
         sl[3*k +: 3] = m_scan[k];
         dc[8*k +: 8] = m_dec[k];
         sd[k] = m_shd[k];
         dt[k] = m_tst[k];
      end
      return {l, it, sl, dc, sd, dt};
   endfunction

   task automatic push_word(input logic [15:0] w);
      for (int b = 15; b >= 0; b--) q.push_back(w[b]);
   endtask

   task automatic push_rand_bits(input int n);
      for (int i = 0; i < n; i++) q.push_back(bit'($urandom_range(1, 0)));
   endtask

   // drive q onto the pins; each sclk phase lasts 2 clk (sclk = clk/4)
   task automatic shift_out(input bit together, input int gap);
      int n, first;
      bit tog;
      n = q.size();
      tog = together && (n > 1);
      first = 0;
      @(negedge clk);
      if (tog) begin
         din = q[0];
         repeat (2) @(negedge clk);
         cs = 1'b0; sclk = 1'b1;
         repeat (2) @(negedge clk);
         sclk = 1'b0;
         first = 1;
      end else begin
         cs = 1'b0;
         repeat (2) @(negedge clk);
      end
      for (int i = first; i < n; i++) begin
         din = q[i];
         repeat (2) @(negedge clk);
         sclk = 1'b1;
         if (tog && i == n - 1) cs = 1'b1;
         repeat (2) @(negedge clk);
         sclk = 1'b0;
      end
      if (!tog) begin
         repeat (2) @(negedge clk);
         cs = 1'b1;
      end
      repeat (gap) @(negedge clk);
   endtask

   task automatic send(input bit together, input int gap);
      shift_out(together, gap);
      model_frame();
      q.delete();
   endtask

   task automatic test_reset();
      model_reset();
      repeat (4) @(negedge clk);
      total++; if (dut_regs !== '0) begin bad++; $display("FAIL reset_regs got=%h want=0", dut_regs); end
      total++; if ({frame_stb, frame_err, bit_count} !== '0) begin bad++;
         $display("FAIL reset_misc got stb=%b err=%b bc=%0d want 0", frame_stb, frame_err, bit_count); end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_shutdown();
      for (int k = 0; k < NCHIP; k++) push_word(16'h0C01);
      send(1'b0, 10);
      total++; if (shutdown_n !== 4'hF) begin bad++; $display("FAIL shdn got=%h want=f", shutdown_n); end
      total++; if (bit_count !== 16'd64) begin bad++; $display("FAIL shdn_bc got=%0d want=64", bit_count); end
      total++; if (stb_seen !== 1 || err_seen !== 0) begin bad++;
         $display("FAIL shdn_pulses got stb=%0d err=%0d want 1/0", stb_seen, err_seen); end
      total++; if (dut_regs !== exp_regs()) begin bad++; $display("FAIL shdn_regs got=%h want=%h", dut_regs, exp_regs()); end
   endtask

   task automatic test_mixed();
      push_word(16'h0155); push_word(16'h08AA); push_word(16'h0A07); push_word(16'h0B05);
      send(1'b0, 10);
      total++; if (leds[199:192] !== 8'h55 || leds[191:184] !== 8'hAA) begin bad++;
         $display("FAIL mixed_digits got=%h/%h want 55/aa", leds[199:192], leds[191:184]); end
      total++; if (intensity[7:4] !== 4'd7 || scan_limit[2:0] !== 3'd5) begin bad++;
         $display("FAIL mixed_ctrl got int=%0d scan=%0d want 7/5", intensity[7:4], scan_limit[2:0]); end
      total++; if (dut_regs !== exp_regs()) begin bad++; $display("FAIL mixed_regs got=%h want=%h", dut_regs, exp_regs()); end
   endtask

   task automatic test_bad_len();
      int lens[3] = '{63, 65, 0};
      for (int i = 0; i < 3; i++) begin
         push_rand_bits(lens[i]);
         send(1'b0, 10);
         total++; if (bit_count !== 16'(lens[i])) begin bad++;
            $display("FAIL badlen_bc got=%0d want=%0d", bit_count, lens[i]); end
         total++; if (err_seen !== exp_err || stb_seen !== exp_stb) begin bad++;
            $display("FAIL badlen_pulses got stb=%0d err=%0d want %0d/%0d", stb_seen, err_seen, exp_stb, exp_err); end
         total++; if (dut_regs !== exp_regs()) begin bad++; $display("FAIL badlen_regs got=%h want=%h", dut_regs, exp_regs()); end
      end
   endtask

   task automatic test_noop();
      for (int k = 0; k < NCHIP; k++) push_word(16'h0133);
      send(1'b0, 10);
      push_word(16'h01FF); push_word(16'h01FF); push_word(16'h0000); push_word(16'h01FF);
      send(1'b0, 10);
      total++; if (leds[71:64] !== 8'h33 || leds[7:0] !== 8'hFF) begin bad++;
         $display("FAIL noop got chip1=%h chip0=%h want 33/ff", leds[71:64], leds[7:0]); end
      total++; if (dut_regs !== exp_regs()) begin bad++; $display("FAIL noop_regs got=%h want=%h", dut_regs, exp_regs()); end
   endtask

   task automatic test_edges();
      // cs and sclk change in the same clk: first and last bits coincide with cs edges
      for (int k = 0; k < NCHIP; k++) push_word(16'($urandom_range(8, 1) << 8) | 16'($urandom_range(255, 0)));
      send(1'b1, 10);
      total++; if (bit_count !== 16'd64) begin bad++; $display("FAIL edges_bc got=%0d want=64", bit_count); end
      total++; if (dut_regs !== exp_regs()) begin bad++; $display("FAIL edges_regs got=%h want=%h", dut_regs, exp_regs()); end
      total++; if (stb_seen !== exp_stb || err_seen !== exp_err) begin bad++;
         $display("FAIL edges_pulses got stb=%0d err=%0d want %0d/%0d", stb_seen, err_seen, exp_stb, exp_err); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(3, 0) != 0) begin
            for (int k = 0; k < NCHIP; k++) push_word(16'($urandom()));
         end else begin
            push_rand_bits($urandom_range(80, 1));
         end
         send(bit'($urandom_range(1, 0)), 10);
         total++; if (dut_regs !== exp_regs()) begin bad++; $display("FAIL rand_regs it=%0d got=%h want=%h", it, dut_regs, exp_regs()); end
         total++; if (bit_count !== 16'(m_bc)) begin bad++; $display("FAIL rand_bc it=%0d got=%0d want=%0d", it, bit_count, m_bc); end
         total++; if (stb_seen !== exp_stb || err_seen !== exp_err) begin bad++;
            $display("FAIL rand_pulses it=%0d got stb=%0d err=%0d want %0d/%0d", it, stb_seen, err_seen, exp_stb, exp_err); end
      end
   endtask

   task automatic test_back_to_back();
      int err0;
      logic [64*NCHIP-1:0] pat;
      err0 = err_seen;
      pat = '0;
      for (int d = 0; d < 8; d++) begin
         for (int k = NCHIP - 1; k >= 0; k--) begin
            logic [7:0] v;
            v = 8'($urandom());
            pat[64*k + 8*d +: 8] = v;
            push_word({4'h0, 4'(d + 1), v});
         end
         send(1'b0, 3);
      end
      repeat (10) @(negedge clk);
      total++; if (leds !== pat) begin bad++; $display("FAIL b2b_leds got=%h want=%h", leds, pat); end
      total++; if (err_seen !== err0 || stb_seen !== exp_stb) begin bad++;
         $display("FAIL b2b_pulses got stb=%0d err=%0d want %0d/%0d", stb_seen, err_seen, exp_stb, err0); end
      total++; if (dut_regs !== exp_regs()) begin bad++; $display("FAIL b2b_regs got=%h want=%h", dut_regs, exp_regs()); end
   endtask

   task automatic test_mid_reset();
      int s0, e0;
      @(negedge clk);
      cs = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         din = 1'($urandom_range(1, 0));
         repeat (2) @(negedge clk);
         sclk = 1'b1;
         repeat (2) @(negedge clk);
         sclk = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      total++; if (dut_regs !== exp_regs()) begin bad++; $display("FAIL midrst_regs got=%h want=0", dut_regs); end
      total++; if ({frame_stb, frame_err, bit_count} !== '0) begin bad++;
         $display("FAIL midrst_misc got stb=%b err=%b bc=%0d want 0", frame_stb, frame_err, bit_count); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      s0 = stb_seen; e0 = err_seen;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         din = 1'b1;
         repeat (2) @(negedge clk);
         sclk = 1'b1;
         repeat (2) @(negedge clk);
         sclk = 1'b0;
      end
      cs = 1'b1;
      repeat (12) @(negedge clk);
      total++; if (stb_seen !== s0 || err_seen !== e0) begin bad++;
         $display("FAIL midrst_pulses got stb=%0d err=%0d want %0d/%0d", stb_seen, err_seen, s0, e0); end
      total++; if (dut_regs !== exp_regs() || bit_count !== 16'd0) begin bad++;
         $display("FAIL midrst_after got=%h bc=%0d want=0", dut_regs, bit_count); end
   endtask

   initial begin
      test_reset();
      test_shutdown();
      test_mixed();
      test_bad_len();
      test_noop();
      test_edges();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
